// File: rtl/button_event_decoder.sv
// Turns a debounced, clk-synchronous button level into single-cycle press, release,
// long-press and auto-repeat pulses, plus a held level. One instance per button.
module button_event_decoder #(
    parameter int               CNT_W         = 16,
    parameter logic [CNT_W-1:0] LONG_CYCLES   = 16'd50000,
    parameter logic [CNT_W-1:0] REPEAT_CYCLES = 16'd10000
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    // state    | meaning
    // WAIT_LOW | after reset; a press already held is ignored until level returns to 0
    // IDLE     | button released, waiting for a press
    // PRESSED  | accepted press, counting towards long-press
    // LONG     | long-press reached, counting repeat intervals
    typedef enum logic [1:0] {WAIT_LOW, IDLE, PRESSED, LONG} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= WAIT_LOW;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            case (state)
                WAIT_LOW: begin
                    if (!level) state <= IDLE;
                end
                IDLE: begin
                    if (level) begin
                        state       <= PRESSED;
                        cnt         <= CNT_W'(1);
                        press_pulse <= 1'b1;
                        held        <= 1'b1;
                    end
                end
                PRESSED: begin
                    // release wins over a long-press landing on the same edge
                    if (!level) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                        cnt           <= '0;
                    end else if (cnt == LONG_CYCLES) begin
                        state      <= LONG;
                        long_pulse <= 1'b1;
                        cnt        <= CNT_W'(1);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LONG: begin
                    if (!level) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                        cnt           <= '0;
                    end else if (cnt == REPEAT_CYCLES) begin
                        repeat_pulse <= 1'b1;
                        cnt          <= CNT_W'(1);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= WAIT_LOW;
                    cnt   <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder: per-edge expected outputs are queued when
// stimulus is driven and compared one edge later.
module tb_button_event_decoder;

    localparam int         CNT_W = 4;
    localparam logic [3:0] LONG_C = 4'd8;
    localparam logic [3:0] REP_C  = 4'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic level = 1'b0;
    logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;

    int         checks = 0;
    int         failures = 0;
    int         repeats_seen = 0;
    int         step_no = 0;
    string      scen = "init";
    logic [4:0] exp_q[$];

    button_event_decoder #(
        .CNT_W        (CNT_W),
        .LONG_CYCLES  (LONG_C),
        .REPEAT_CYCLES(REP_C)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .level        (level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] mk(logic p, logic r, logic l, logic rp, logic h);
        return {p, r, l, rp, h};
    endfunction

    task automatic chk(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one edge worth of inputs, then compare the outputs that edge produced.
    task automatic step(logic r, logic lvl, logic [4:0] e);
        logic [4:0] x;
        string      t;
        rst   = r;
        level = lvl;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        x = exp_q.pop_front();
        if (repeat_pulse) repeats_seen++;
        t = $sformatf("%s@%0d", scen, step_no);
        chk({t, ".press"},   press_pulse,   x[4]);
        chk({t, ".release"}, release_pulse, x[3]);
        chk({t, ".long"},    long_pulse,    x[2]);
        chk({t, ".repeat"},  repeat_pulse,  x[1]);
        chk({t, ".held"},    held,          x[0]);
    endtask

    // Hold level=1 for n edges starting at E0 (block must be in IDLE).
    task automatic hold_only(int n);
        for (int j = 0; j < n; j++) begin
            step(1'b0, 1'b1, mk(j == 0, 1'b0, j == int'(LONG_C),
                                 (j > int'(LONG_C)) && ((j - int'(LONG_C)) % int'(REP_C) == 0),
                                 1'b1));
        end
    endtask

    task automatic hold_seq(int n);
        hold_only(n);
        step(1'b0, 1'b0, mk(0, 1, 0, 0, 0));
        step(1'b0, 1'b0, mk(0, 0, 0, 0, 0));
    endtask

    initial begin
        // 1: basic press/release
        scen = "s1_rst";
        step(1'b1, 1'b0, 5'b0);
        step(1'b1, 1'b0, 5'b0);
        scen = "s1";
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'b0);
        hold_seq(3);

        // 2: long-press exactly at E0+8, release next edge
        scen = "s2";
        hold_seq(9);

        // 3: long plus three repeats
        scen = "s3";
        repeats_seen = 0;
        hold_seq(21);
        checks++;
        assert (repeats_seen == 3) else begin
            failures++;
            $error("FAIL s3.repeat_count observed=%0d expected=%0d", repeats_seen, 3);
        end

        // single-cycle level pulse
        scen = "s1b";
        hold_seq(1);

        // 4: press held through reset deassertion is ignored
        scen = "s4";
        step(1'b1, 1'b1, 5'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 5'b0);
        step(1'b0, 1'b0, 5'b0);
        hold_seq(2);

        // 5: release on the edge where long would fire
        scen = "s5";
        hold_seq(8);

        // 6: reset while in LONG with level still high
        scen = "s6";
        hold_only(10);
        step(1'b1, 1'b1, 5'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 5'b0);
        step(1'b0, 1'b0, 5'b0);
        hold_seq(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
